// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: MA has fixed priority, DMA is force-granted after
// STARVE_MAX consecutive denials; read data returns one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_gnt,
  output logic              ma_rvalid,
  output logic [DATA_W-1:0] ma_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o,
  output logic [3:0]        starve_cnt
);

  // Handshake: a requester holds req and payload stable until its gnt;
  // a transfer happens in the cycle where req & gnt; reads answer one cycle later.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_MA   = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       force_dma;

  assign force_dma  = dma_req & (cnt_q == STARVE_LIM);
  assign dma_gnt    = dma_req & (~ma_req | force_dma);
  assign ma_gnt     = ma_req & ~dma_gnt;
  assign stall_o    = ma_req & ~ma_gnt;
  assign starve_cnt = cnt_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (ma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ma_we;
      mem_addr  = ma_addr;
      mem_wdata = ma_wdata;
    end
  end

  // Counter only moves while DMA is waiting; any grant or drop clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req || dma_gnt) begin
      cnt_d = 4'd0;
    end else if (ma_gnt && (cnt_q != STARVE_LIM)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (ma_gnt && !ma_we) begin
      owner_d = OWN_MA;
    end else if (dma_gnt && !dma_we) begin
      owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      cnt_q   <= 4'd0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // The owner decode doubles as the visible response-FSM state.
  assign ma_rvalid  = (owner_q == OWN_MA);
  assign dma_rvalid = (owner_q == OWN_DMA);
  assign ma_rdata   = ma_rvalid  ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with hand sequences for
// reset-mid-read and a back-to-back DMA read stream.
module tb_dmem_arbiter;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [63:0] Z64 = 64'h0;
  localparam logic [7:0]  Z8  = 8'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ma_req = 1'b0, ma_we = 1'b0;
  logic [7:0]  ma_addr = '0;
  logic [63:0] ma_wdata = '0;
  logic        ma_gnt, ma_rvalid;
  logic [63:0] ma_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0]  dma_addr = '0;
  logic [63:0] dma_wdata = '0;
  logic        dma_gnt, dma_rvalid;
  logic [63:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        stall_o;
  logic [3:0]  starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_o(stall_o), .starve_cnt(starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic mr; logic mw; logic [7:0] ma; logic [63:0] mwd;
    logic dr; logic dw; logic [7:0] da; logic [63:0] dwd;
    logic [63:0] rd;
    logic e_mg; logic e_dg; logic e_en; logic e_we; logic [7:0] e_addr; logic [63:0] e_wd;
    logic e_st; logic [3:0] e_cnt;
    logic e_mrv; logic [63:0] e_mrd; logic e_drv; logic [63:0] e_drd;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    ma_req = v.mr; ma_we = v.mw; ma_addr = v.ma; ma_wdata = v.mwd;
    dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dwd;
    mem_rdata = v.rd;
    @(negedge clk);
    check($sformatf("v%0d ma_gnt", idx), 64'(ma_gnt), 64'(v.e_mg));
    check($sformatf("v%0d dma_gnt", idx), 64'(dma_gnt), 64'(v.e_dg));
    check($sformatf("v%0d mem_en", idx), 64'(mem_en), 64'(v.e_en));
    check($sformatf("v%0d mem_we", idx), 64'(mem_we), 64'(v.e_we));
    check($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.e_addr));
    check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wd);
    check($sformatf("v%0d stall_o", idx), 64'(stall_o), 64'(v.e_st));
    check($sformatf("v%0d starve_cnt", idx), 64'(starve_cnt), 64'(v.e_cnt));
    check($sformatf("v%0d ma_rvalid", idx), 64'(ma_rvalid), 64'(v.e_mrv));
    check($sformatf("v%0d ma_rdata", idx), ma_rdata, v.e_mrd);
    check($sformatf("v%0d dma_rvalid", idx), 64'(dma_rvalid), 64'(v.e_drv));
    check($sformatf("v%0d dma_rdata", idx), dma_rdata, v.e_drd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          mr mw ma     mwd         dr dw da     dwd         rd           | mg dg en we addr   wd          st cnt   mrv mrd        drv drd
    vecs[0]  = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        Z64,          L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[1]  = '{H, L, 8'h11, Z64,        L, L, Z8,    Z64,        Z64,          H, L, H, L, 8'h11, Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[2]  = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h5,        L, L, L, L, Z8,    Z64,        L, 4'd0, H, 64'h5,     L, Z64};
    vecs[3]  = '{L, L, Z8,    Z64,        H, H, 8'h02, 64'h3,      64'h99,       L, H, H, H, 8'h02, 64'h3,      L, 4'd0, L, Z64,       L, Z64};
    vecs[4]  = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h77,       L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[5]  = '{H, L, 8'h05, Z64,        L, L, Z8,    Z64,        64'hAA,       H, L, H, L, 8'h05, Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[6]  = '{L, L, Z8,    Z64,        H, L, 8'h06, Z64,        64'h55,       L, H, H, L, 8'h06, Z64,        L, 4'd0, H, 64'h55,    L, Z64};
    vecs[7]  = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h66,       L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       H, 64'h66};
    vecs[8]  = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h11,       L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[9]  = '{H, H, 8'h20, 64'hA0,     H, L, 8'h30, Z64,        Z64,          H, L, H, H, 8'h20, 64'hA0,     L, 4'd0, L, Z64,       L, Z64};
    vecs[10] = '{H, H, 8'h20, 64'hA0,     H, L, 8'h30, Z64,        Z64,          H, L, H, H, 8'h20, 64'hA0,     L, 4'd1, L, Z64,       L, Z64};
    vecs[11] = '{H, H, 8'h20, 64'hA0,     H, L, 8'h30, Z64,        Z64,          H, L, H, H, 8'h20, 64'hA0,     L, 4'd2, L, Z64,       L, Z64};
    vecs[12] = '{H, H, 8'h20, 64'hA0,     H, L, 8'h30, Z64,        Z64,          H, L, H, H, 8'h20, 64'hA0,     L, 4'd3, L, Z64,       L, Z64};
    vecs[13] = '{H, H, 8'h20, 64'hA0,     H, L, 8'h30, Z64,        Z64,          L, H, H, L, 8'h30, Z64,        H, 4'd4, L, Z64,       L, Z64};
    vecs[14] = '{H, H, 8'h20, 64'hA0,     L, L, Z8,    Z64,        64'hD0,       H, L, H, H, 8'h20, 64'hA0,     L, 4'd0, L, Z64,       H, 64'hD0};
    vecs[15] = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        Z64,          L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[16] = '{H, H, 8'h21, 64'hB1,     H, H, 8'h31, 64'hC1,     Z64,          H, L, H, H, 8'h21, 64'hB1,     L, 4'd0, L, Z64,       L, Z64};
    vecs[17] = '{H, H, 8'h21, 64'hB1,     H, H, 8'h31, 64'hC1,     Z64,          H, L, H, H, 8'h21, 64'hB1,     L, 4'd1, L, Z64,       L, Z64};
    vecs[18] = '{H, H, 8'h21, 64'hB1,     H, H, 8'h31, 64'hC1,     Z64,          H, L, H, H, 8'h21, 64'hB1,     L, 4'd2, L, Z64,       L, Z64};
    vecs[19] = '{H, H, 8'h21, 64'hB1,     L, L, Z8,    Z64,        Z64,          H, L, H, H, 8'h21, 64'hB1,     L, 4'd3, L, Z64,       L, Z64};
    vecs[20] = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        Z64,          L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[21] = '{H, L, 8'h40, Z64,        L, L, Z8,    Z64,        64'hEE,       H, L, H, L, 8'h40, Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[22] = '{H, L, 8'h41, Z64,        L, L, Z8,    Z64,        64'h40,       H, L, H, L, 8'h41, Z64,        L, 4'd0, H, 64'h40,    L, Z64};
    vecs[23] = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h41,       L, L, L, L, Z8,    Z64,        L, 4'd0, H, 64'h41,    L, Z64};
    vecs[24] = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h12,       L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[25] = '{H, L, 8'h50, Z64,        H, L, 8'h51, Z64,        Z64,          H, L, H, L, 8'h50, Z64,        L, 4'd0, L, Z64,       L, Z64};
    vecs[26] = '{L, L, Z8,    Z64,        H, L, 8'h51, Z64,        64'h50,       L, H, H, L, 8'h51, Z64,        L, 4'd1, H, 64'h50,    L, Z64};
    vecs[27] = '{L, L, Z8,    Z64,        L, L, Z8,    Z64,        64'h51,       L, L, L, L, Z8,    Z64,        L, 4'd0, L, Z64,       H, 64'h51};

    // reset state
    drive_idle();
    mem_rdata = 64'hFFFF;
    #12;
    check("reset starve_cnt", 64'(starve_cnt), 64'd0);
    check("reset ma_rvalid", 64'(ma_rvalid), 64'd0);
    check("reset ma_rdata", ma_rdata, 64'd0);
    check("reset dma_rvalid", 64'(dma_rvalid), 64'd0);
    check("reset dma_rdata", dma_rdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      apply_vec(vecs[i], i);
    end

    // reset between a read grant and its response
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 8'h33;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h34;
    @(negedge clk);
    check("rst_mid ma_gnt", 64'(ma_gnt), 64'd1);
    @(posedge clk);
    #1;
    drive_idle();
    mem_rdata = 64'hBEEF;
    check("rst_mid pre ma_rvalid", 64'(ma_rvalid), 64'd1);
    check("rst_mid pre starve_cnt", 64'(starve_cnt), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid ma_rvalid", 64'(ma_rvalid), 64'd0);
    check("rst_mid ma_rdata", ma_rdata, 64'd0);
    check("rst_mid starve_cnt", 64'(starve_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("rst_mid post ma_rvalid", 64'(ma_rvalid), 64'd0);
      check("rst_mid post dma_rvalid", 64'(dma_rvalid), 64'd0);
    end

    // back-to-back DMA reads, responses scored through exp_q
    for (int k = 0; k < 4; k++) begin
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'(8'h60 + k);
      mem_rdata = 64'(k) * 64'h1111;
      if (k > 0) exp_q.push_back(64'(k) * 64'h1111);
      @(negedge clk);
      check("b2b dma_gnt", 64'(dma_gnt), 64'd1);
      check("b2b mem_addr", 64'(mem_addr), 64'(8'h60 + k));
      if (k > 0) begin
        check("b2b dma_rvalid", 64'(dma_rvalid), 64'd1);
        check("b2b dma_rdata", dma_rdata, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
    mem_rdata = 64'h4444;
    exp_q.push_back(64'h4444);
    @(negedge clk);
    check("b2b last dma_rvalid", 64'(dma_rvalid), 64'd1);
    check("b2b last dma_rdata", dma_rdata, exp_q.pop_front());
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b tail dma_rvalid", 64'(dma_rvalid), 64'd0);
    check("b2b queue empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
